// File: rtl/instr_dispatch_if.sv
// instr_dispatch_if: run/instruction/start-done bundle between the dispatcher and the instruction FSMs
interface instr_dispatch_if #(
   parameter int NUM_OPS = 8,
   parameter int PC_W    = 6
);
   logic               run;
   logic [15:0]        instr_in;
   logic [NUM_OPS-1:0] done_in;
   logic [PC_W-1:0]    pc_out;
   logic [NUM_OPS-1:0] start_out;
   logic [5:0]         ri_out;
   logic [5:0]         rj_out;
   logic               busy;
   logic               halted;
   logic               err;
   modport master (
      input  run, instr_in, done_in,
      output pc_out, start_out, ri_out, rj_out, busy, halted, err
   );
   modport slave (
      output run, instr_in, done_in,
      input  pc_out, start_out, ri_out, rj_out, busy, halted, err
   );
endinterface

// File: rtl/instr_dispatch.sv
// instr_dispatch: fetch/decode/dispatch controller driving one instruction FSM at a time.
// Defining INSTR_DISPATCH_TIMEOUT_EN adds a done watchdog that traps to ERROR.
module instr_dispatch #(
   parameter int NUM_OPS     = 8,
   parameter int PC_W        = 6,
   parameter int TIMEOUT_CYC = 64
) (
   input logic              clk,
   input logic              reset,
   instr_dispatch_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, HALTED, ERROR} state_t;
   state_t             state, next_state;
   logic [15:0]        ir;
   logic [PC_W-1:0]    pc;
   logic [3:0]         op;
   logic [NUM_OPS-1:0] op_mask;
   logic               halt_op, bad_op, done_hit, timed_out;

   if (NUM_OPS < 1 || NUM_OPS > 15 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("instr_dispatch: NUM_OPS must be 1..15 and TIMEOUT_CYC >= 1");
   end

   assign op       = ir[15:12];
   assign op_mask  = NUM_OPS'(1) << op;
   assign halt_op  = op == 4'hF;
   assign bad_op   = !halt_op && 32'(op) >= NUM_OPS;
   assign done_hit = |(bus.done_in & op_mask);

`ifdef INSTR_DISPATCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) wait_cnt <= '0;
      else if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT && !done_hit) wait_cnt <= wait_cnt + CNT_W'(1);
   assign timed_out = wait_cnt == CNT_W'(TIMEOUT_CYC - 1);
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = bus.run ? FETCH : IDLE;
         FETCH:   next_state = DECODE;
         DECODE:  next_state = halt_op ? HALTED : bad_op ? ERROR : ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    next_state = done_hit ? (bus.run ? FETCH : IDLE) : timed_out ? ERROR : WAIT;
         default: next_state = state;
      endcase
   end

   // done is only honoured in WAIT, so a pulse during ISSUE never advances the PC
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ir <= '0;
         pc <= '0;
      end else begin
         if (state == FETCH) ir <= bus.instr_in;
         if (state == WAIT && done_hit) pc <= pc + PC_W'(1);
      end

   assign bus.pc_out    = pc;
   assign bus.start_out = (state == ISSUE) ? op_mask : '0;
   assign bus.ri_out    = ir[11:6];
   assign bus.rj_out    = ir[5:0];
   assign bus.busy      = !(state inside {IDLE, HALTED, ERROR});
   assign bus.halted    = state == HALTED;
   assign bus.err       = state == ERROR;
endmodule

// File: tb/tb_instr_dispatch.sv
// tb_instr_dispatch: table-driven single-instruction vectors plus hand sequences for multi-cycle cases
module tb_instr_dispatch;
   logic       clk;
   logic       reset;
   logic [15:0] mem [64];
   logic [7:0] auto_mask, man_mask, pend_mask;
   logic       resp_en;
   int         pend, cyc, starts, multi, checks, errors;

   instr_dispatch_if #(.NUM_OPS(8), .PC_W(6)) bus ();
   instr_dispatch #(.NUM_OPS(8), .PC_W(6), .TIMEOUT_CYC(64)) dut (.clk(clk), .reset(reset), .bus(bus));

   assign bus.instr_in = mem[bus.pc_out];
   assign bus.done_in  = auto_mask | man_mask;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  s3;
      logic        b3, h3, e3;
      logic [5:0]  ri, rj, pc6;
      logic        hend, eend;
      logic [5:0]  pcend;
      int          nst;
   } vec_t;
   vec_t vt [8];

   // FSM model: answers each start with done two cycles later
   initial begin
      auto_mask = '0;
      pend = 0;
      pend_mask = '0;
      forever begin
         @(negedge clk);
         auto_mask = '0;
         if (reset) pend = 0;
         else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) auto_mask = pend_mask;
            end
            if (resp_en && bus.start_out != 0) begin
               pend_mask = bus.start_out;
               pend = 2;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (bus.start_out != 0) starts++;
      if ($countones(bus.start_out) > 1) multi++;
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic fill(input logic [15:0] w);
      for (int i = 0; i < 64; i++) mem[i] = w;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.run = 1'b0;
      man_mask = '0;
      resp_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      starts = 0;
      multi = 0;
   endtask

   initial begin
      reset = 1'b1;
      bus.run = 1'b0;
      man_mask = '0;
      resp_en = 1'b1;
      checks = 0;
      errors = 0;
      cyc = 0;
      fill(16'hF000);
      vt[0] = '{16'h7043, 8'h80, 1'b1, 1'b0, 1'b0, 6'h01, 6'h03, 6'd1, 1'b1, 1'b0, 6'd1, 1};
      vt[1] = '{16'h0000, 8'h01, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 6'd1, 1'b1, 1'b0, 6'd1, 1};
      vt[2] = '{16'h3FFF, 8'h08, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h3F, 6'd1, 1'b1, 1'b0, 6'd1, 1};
      vt[3] = '{16'h5A95, 8'h20, 1'b1, 1'b0, 1'b0, 6'h2A, 6'h15, 6'd1, 1'b1, 1'b0, 6'd1, 1};
      vt[4] = '{16'hF000, 8'h00, 1'b0, 1'b1, 1'b0, 6'h00, 6'h00, 6'd0, 1'b1, 1'b0, 6'd0, 0};
      vt[5] = '{16'h9000, 8'h00, 1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 6'd0, 1'b0, 1'b1, 6'd0, 0};
      vt[6] = '{16'h8123, 8'h00, 1'b0, 1'b0, 1'b1, 6'h04, 6'h23, 6'd0, 1'b0, 1'b1, 6'd0, 0};
      vt[7] = '{16'hE7C1, 8'h00, 1'b0, 1'b0, 1'b1, 6'h1F, 6'h01, 6'd0, 1'b0, 1'b1, 6'd0, 0};

      do_reset();
      chk("rst pc", bus.pc_out, 0);
      chk("rst start", bus.start_out, 0);
      chk("rst ri", bus.ri_out, 0);
      chk("rst rj", bus.rj_out, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst halted", bus.halted, 0);
      chk("rst err", bus.err, 0);

      for (int v = 0; v < 8; v++) begin
         do_reset();
         fill(16'hF000);
         mem[0] = vt[v].instr;
         bus.run = 1'b1;
         to_cyc(3);
         chk($sformatf("v%0d start", v), bus.start_out, vt[v].s3);
         chk($sformatf("v%0d busy", v), bus.busy, vt[v].b3);
         chk($sformatf("v%0d halted", v), bus.halted, vt[v].h3);
         chk($sformatf("v%0d err", v), bus.err, vt[v].e3);
         chk($sformatf("v%0d ri", v), bus.ri_out, vt[v].ri);
         chk($sformatf("v%0d rj", v), bus.rj_out, vt[v].rj);
         to_cyc(6);
         chk($sformatf("v%0d pc6", v), bus.pc_out, vt[v].pc6);
         to_cyc(12);
         chk($sformatf("v%0d halted end", v), bus.halted, vt[v].hend);
         chk($sformatf("v%0d err end", v), bus.err, vt[v].eend);
         chk($sformatf("v%0d pc end", v), bus.pc_out, vt[v].pcend);
         chk($sformatf("v%0d starts", v), starts, vt[v].nst);
         chk($sformatf("v%0d onehot", v), multi, 0);
      end

      // two Movi then HALT
      do_reset();
      fill(16'hF000);
      mem[0] = 16'h7043;
      mem[1] = 16'h0105;
      bus.run = 1'b1;
      to_cyc(3);
      chk("prog start0", bus.start_out, 8'h80);
      to_cyc(7);
      chk("prog idle start", bus.start_out, 0);
      to_cyc(8);
      chk("prog start1", bus.start_out, 8'h01);
      to_cyc(9);
      chk("prog ri1", bus.ri_out, 6'h04);
      chk("prog rj1", bus.rj_out, 6'h05);
      to_cyc(13);
      chk("prog halted", bus.halted, 1);
      chk("prog busy", bus.busy, 0);
      to_cyc(20);
      chk("prog pc", bus.pc_out, 2);
      chk("prog starts", starts, 2);

      // done in ISSUE and wrong-op done are both ignored
      do_reset();
      fill(16'hF000);
      mem[0] = 16'h7043;
      resp_en = 1'b0;
      bus.run = 1'b1;
      to_cyc(3);
      man_mask = 8'h80;
      to_cyc(4);
      man_mask = 8'h04;
      to_cyc(5);
      man_mask = 8'h00;
      to_cyc(8);
      chk("spur pc", bus.pc_out, 0);
      chk("spur busy", bus.busy, 1);
      chk("spur start", bus.start_out, 0);
      man_mask = 8'h80;
      to_cyc(9);
      man_mask = 8'h00;
      chk("spur adv pc", bus.pc_out, 1);
      to_cyc(11);
      chk("spur halted", bus.halted, 1);

      // run dropped mid-WAIT, then reasserted
      do_reset();
      fill(16'hF000);
      mem[0] = 16'h7043;
      mem[1] = 16'h0000;
      bus.run = 1'b1;
      to_cyc(4);
      bus.run = 1'b0;
      to_cyc(6);
      chk("drop busy", bus.busy, 0);
      chk("drop pc", bus.pc_out, 1);
      to_cyc(9);
      chk("drop idle busy", bus.busy, 0);
      chk("drop starts", starts, 1);
      bus.run = 1'b1;
      to_cyc(10);
      chk("resume busy", bus.busy, 1);
      chk("resume pc", bus.pc_out, 1);
      to_cyc(12);
      chk("resume start", bus.start_out, 8'h01);

      // PC wrap after 64 instructions
      do_reset();
      fill(16'h0000);
      bus.run = 1'b1;
      to_cyc(316);
      chk("wrap pc63", bus.pc_out, 63);
      to_cyc(320);
      chk("wrap pc63 wait", bus.pc_out, 63);
      to_cyc(321);
      chk("wrap pc0", bus.pc_out, 0);
      chk("wrap err", bus.err, 0);

      // no done ever returned
      do_reset();
      fill(16'hF000);
      mem[0] = 16'h7043;
      resp_en = 1'b0;
      bus.run = 1'b1;
`ifdef INSTR_DISPATCH_TIMEOUT_EN
      to_cyc(67);
      chk("to err early", bus.err, 0);
      chk("to busy early", bus.busy, 1);
      to_cyc(68);
      chk("to err", bus.err, 1);
      chk("to busy", bus.busy, 0);
      chk("to pc", bus.pc_out, 0);
`else
      to_cyc(200);
      chk("hang busy", bus.busy, 1);
      chk("hang err", bus.err, 0);
      chk("hang pc", bus.pc_out, 0);
      chk("hang starts", starts, 1);
`endif

      // asynchronous reset in WAIT
      do_reset();
      fill(16'hF000);
      mem[0] = 16'h7043;
      resp_en = 1'b0;
      bus.run = 1'b1;
      to_cyc(5);
      chk("pre ri", bus.ri_out, 1);
      chk("pre rj", bus.rj_out, 3);
      chk("pre busy", bus.busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst pc", bus.pc_out, 0);
      chk("arst start", bus.start_out, 0);
      chk("arst ri", bus.ri_out, 0);
      chk("arst rj", bus.rj_out, 0);
      chk("arst busy", bus.busy, 0);
      chk("arst halted", bus.halted, 0);
      chk("arst err", bus.err, 0);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
